// File: rtl/mps_op_cmd_arbiter.sv
// Operation command arbiter: picks one of three requesters,
// issues ON/OFF to the sequencers and reports the outcome.
module mps_op_cmd_arbiter #(
  parameter logic [31:0] P_TIMEOUT = 32'd500_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_req_valid,
  input  logic [5:0] i_req_cmd,
  output logic [2:0] o_req_ready,
  input  logic       i_intl,
  input  logic [3:0] i_on_state,
  input  logic [3:0] i_off_state,
  output logic       o_op_on_flag,
  output logic       o_op_off_flag,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_done_id,
  output logic [1:0] o_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam logic [1:0] LP_CMD_ON  = 2'b01;
  localparam logic [1:0] LP_CMD_OFF = 2'b10;

  localparam logic [1:0] LP_RES_OK  = 2'b00;
  localparam logic [1:0] LP_RES_FL  = 2'b01;
  localparam logic [1:0] LP_RES_TMO = 2'b10;
  localparam logic [1:0] LP_RES_REJ = 2'b11;

  localparam logic [3:0] LP_ON_IDLE = 4'd0;
  localparam logic [3:0] LP_ON_SYS  = 4'd14;
  localparam logic [3:0] LP_ON_FAIL = 4'd15;
  localparam logic [3:0] LP_OFF_IDL = 4'd0;
  localparam logic [3:0] LP_OFF_SYS = 4'd3;

  localparam logic [31:0] LP_LAST = P_TIMEOUT - 32'd1;

  state_t      r_state;
  logic [1:0]  r_rr;
  logic [1:0]  r_win;
  logic [1:0]  r_cmd;
  logic [31:0] r_cnt;
  logic [2:0]  r_ready;
  logic        r_on;
  logic        r_off;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_done_id;
  logic [1:0]  r_result;

  // slot 3 is a dummy so a 2-bit index never leaves the array
  logic [1:0]  w_cmd [0:3];
  logic [3:0]  w_valid;
  logic [1:0]  w_win;
  logic        w_off_hit;
  logic        w_any_hit;
  logic [1:0]  w_idx;
  logic        w_reject;
  logic        w_cpl;
  logic [1:0]  w_cpl_res;
  logic        w_tmo;

  function automatic logic [1:0] f_mod3(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign w_cmd[0] = i_req_cmd[1:0];
  assign w_cmd[1] = i_req_cmd[3:2];
  assign w_cmd[2] = i_req_cmd[5:4];
  assign w_cmd[3] = 2'b00;
  assign w_valid  = {1'b0, i_req_valid};

  // winner: OFF class first, then anything; round-robin from r_rr
  always_comb begin
    w_win     = 2'd0;
    w_off_hit = 1'b0;
    w_any_hit = 1'b0;
    w_idx     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      w_idx = f_mod3(r_rr, 2'(k));
      if (!w_off_hit && w_valid[w_idx]
          && w_cmd[w_idx] == LP_CMD_OFF) begin
        w_win     = w_idx;
        w_off_hit = 1'b1;
      end
    end
    if (!w_off_hit) begin
      for (int k = 0; k < 3; k++) begin
        w_idx = f_mod3(r_rr, 2'(k));
        if (!w_any_hit && w_valid[w_idx]) begin
          w_win     = w_idx;
          w_any_hit = 1'b1;
        end
      end
    end
  end

  // legality of the latched command against current sequencer state
  always_comb begin
    w_reject = 1'b1;
    unique case (1'b1)
      (r_cmd == LP_CMD_ON):
        w_reject = i_intl || (i_on_state != LP_ON_IDLE);
      (r_cmd == LP_CMD_OFF):
        w_reject = (i_off_state != LP_OFF_IDL);
      default:
        w_reject = 1'b1;
    endcase
  end

  // completion detect; interlock alone never completes a command
  always_comb begin
    w_cpl     = 1'b0;
    w_cpl_res = LP_RES_OK;
    if (r_cmd == LP_CMD_ON) begin
      if (i_on_state == LP_ON_SYS) begin
        w_cpl     = 1'b1;
        w_cpl_res = LP_RES_OK;
      end else if (i_on_state == LP_ON_FAIL) begin
        w_cpl     = 1'b1;
        w_cpl_res = LP_RES_FL;
      end
    end else if (r_cmd == LP_CMD_OFF) begin
      if (i_off_state == LP_OFF_SYS) begin
        w_cpl     = 1'b1;
        w_cpl_res = LP_RES_OK;
      end
    end
  end

  assign w_tmo = (r_cnt == LP_LAST);

  // command FSM with all outputs registered
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_rr      <= 2'd0;
      r_win     <= 2'd0;
      r_cmd     <= 2'd0;
      r_cnt     <= 32'd0;
      r_ready   <= 3'd0;
      r_on      <= 1'b0;
      r_off     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 2'd0;
      r_result  <= 2'd0;
    end else begin
      r_ready <= 3'd0;
      r_on    <= 1'b0;
      r_off   <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|i_req_valid) begin
            r_state <= S_GRANT;
            r_win   <= w_win;
            r_cmd   <= w_cmd[w_win];
            r_rr    <= f_mod3(w_win, 2'd1);
            r_ready <= 3'(3'b001 << w_win);
            r_busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_reject) begin
            r_state   <= S_REPORT;
            r_done    <= 1'b1;
            r_done_id <= r_win;
            r_result  <= LP_RES_REJ;
          end else begin
            r_state <= S_ISSUE;
            r_on    <= (r_cmd == LP_CMD_ON);
            r_off   <= (r_cmd == LP_CMD_OFF);
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= 32'd0;
        end
        S_WAIT: begin
          if (w_cpl) begin
            r_state   <= S_REPORT;
            r_done    <= 1'b1;
            r_done_id <= r_win;
            r_result  <= w_cpl_res;
          end else if (w_tmo) begin
            r_state   <= S_REPORT;
            r_done    <= 1'b1;
            r_done_id <= r_win;
            r_result  <= LP_RES_TMO;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready   = r_ready;
  assign o_op_on_flag  = r_on;
  assign o_op_off_flag = r_off;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_done_id     = r_done_id;
  assign o_result      = r_result;

endmodule

// File: tb/tb_mps_op_cmd_arbiter.sv
// Bench for mps_op_cmd_arbiter: cycle table plus
// timeout and reset sequences.
module tb_mps_op_cmd_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [2:0] i_req_valid = '0;
  logic [5:0] i_req_cmd = '0;
  logic [2:0] o_req_ready;
  logic       i_intl = 1'b0;
  logic [3:0] i_on_state = '0;
  logic [3:0] i_off_state = '0;
  logic       o_op_on_flag;
  logic       o_op_off_flag;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_done_id;
  logic [1:0] o_result;

  int checks = 0;
  int errors = 0;

  mps_op_cmd_arbiter #(.P_TIMEOUT(32'd100)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .i_req_cmd    (i_req_cmd),
    .o_req_ready  (o_req_ready),
    .i_intl       (i_intl),
    .i_on_state   (i_on_state),
    .i_off_state  (i_off_state),
    .o_op_on_flag (o_op_on_flag),
    .o_op_off_flag(o_op_off_flag),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_done_id    (o_done_id),
    .o_result     (o_result)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0] v;
    logic [5:0] c;
    logic       intl;
    logic [3:0] on;
    logic [3:0] off;
    logic [2:0] rdy;
    logic       onf;
    logic       offf;
    logic       busy;
    logic       done;
    logic [1:0] id;
    logic [1:0] res;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic add(input logic [2:0] v, input logic [5:0] c,
                     input logic intl, input logic [3:0] on,
                     input logic [3:0] off, input logic [2:0] rdy,
                     input logic onf, input logic offf,
                     input logic busy, input logic done,
                     input logic [1:0] id, input logic [1:0] res);
    vec_t t;
    t.v = v; t.c = c; t.intl = intl; t.on = on; t.off = off;
    t.rdy = rdy; t.onf = onf; t.offf = offf; t.busy = busy;
    t.done = done; t.id = id; t.res = res;
    tbl.push_back(t);
  endtask

  task automatic all_out(input string nm, input logic [2:0] rdy,
                         input logic onf, input logic offf,
                         input logic busy, input logic done,
                         input logic [1:0] id,
                         input logic [1:0] res);
    chk({nm, " rdy"}, 32'(o_req_ready), 32'(rdy));
    chk({nm, " onf"}, 32'(o_op_on_flag), 32'(onf));
    chk({nm, " offf"}, 32'(o_op_off_flag), 32'(offf));
    chk({nm, " busy"}, 32'(o_busy), 32'(busy));
    chk({nm, " done"}, 32'(o_done), 32'(done));
    chk({nm, " id"}, 32'(o_done_id), 32'(id));
    chk({nm, " res"}, 32'(o_result), 32'(res));
  endtask

  task automatic set_in(input logic [2:0] v, input logic [5:0] c,
                        input logic intl, input logic [3:0] on,
                        input logic [3:0] off);
    i_req_valid = v; i_req_cmd = c; i_intl = intl;
    i_on_state = on; i_off_state = off;
  endtask

  task automatic wait_tmo(input string nm, input int exp_n,
                          input logic [1:0] exp_res);
    int n;
    n = 0;
    set_in(3'b001, 6'b000010, 0, 0, 0);
    tick();
    chk({nm, " rdy"}, 32'(o_req_ready), 32'd1);
    tick();
    chk({nm, " offf"}, 32'(o_op_off_flag), 32'd1);
    set_in(3'b000, 6'b0, 0, 0, 4'd1);
    tick();
    chk({nm, " wait"}, 32'(o_busy), 32'd1);
    while (n < 200 && !o_done) begin
      if (exp_res == 2'b00 && n == exp_n - 1) i_off_state = 4'd3;
      tick();
      n++;
    end
    chk({nm, " cycles"}, 32'(n), 32'(exp_n));
    chk({nm, " res"}, 32'(o_result), 32'(exp_res));
    chk({nm, " id"}, 32'(o_done_id), 32'd0);
    set_in(3'b000, 6'b0, 0, 0, 0);
    tick();
    chk({nm, " idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    // all ON, held: served 0,1,2
    add(3'b111, 6'h15, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0);
    add(3'b111, 6'h15, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0, 0);
    add(3'b110, 6'h14, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0);
    add(3'b110, 6'h14, 0, 14, 0, 3'b000, 0, 0, 1, 1, 0, 0);
    add(3'b110, 6'h14, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    add(3'b110, 6'h14, 0, 0, 0, 3'b010, 0, 0, 1, 0, 0, 0);
    add(3'b110, 6'h14, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0, 0);
    add(3'b100, 6'h10, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0);
    add(3'b100, 6'h10, 0, 14, 0, 3'b000, 0, 0, 1, 1, 1, 0);
    add(3'b100, 6'h10, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    add(3'b100, 6'h10, 0, 0, 0, 3'b100, 0, 0, 1, 0, 1, 0);
    add(3'b100, 6'h10, 0, 0, 0, 3'b000, 1, 0, 1, 0, 1, 0);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 1, 0, 1, 0);
    add(3'b000, 6'h00, 0, 14, 0, 3'b000, 0, 0, 1, 1, 2, 0);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2, 0);
    // pointer back at 0: req0 beats req1; intl rejects
    add(3'b011, 6'h05, 0, 0, 0, 3'b001, 0, 0, 1, 0, 2, 0);
    add(3'b011, 6'h05, 1, 0, 0, 3'b000, 0, 0, 1, 1, 0, 3);
    add(3'b010, 6'h04, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 3);
    // req1 ON to OK
    add(3'b010, 6'h04, 0, 0, 0, 3'b010, 0, 0, 1, 0, 0, 3);
    add(3'b010, 6'h04, 0, 0, 0, 3'b000, 1, 0, 1, 0, 0, 3);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 3);
    add(3'b000, 6'h00, 1, 3, 0, 3'b000, 0, 0, 1, 0, 0, 3);
    add(3'b000, 6'h00, 0, 14, 0, 3'b000, 0, 0, 1, 1, 1, 0);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0);
    // ON under interlock: reject, no flag
    add(3'b001, 6'h01, 1, 0, 0, 3'b001, 0, 0, 1, 0, 1, 0);
    add(3'b001, 6'h01, 1, 0, 0, 3'b000, 0, 0, 1, 1, 0, 3);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 3);
    // req0 ON + req2 OFF: OFF first, req0 after REPORT
    add(3'b101, 6'h21, 0, 0, 0, 3'b100, 0, 0, 1, 0, 0, 3);
    add(3'b101, 6'h21, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0, 3);
    add(3'b001, 6'h01, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 3);
    add(3'b001, 6'h01, 0, 0, 3, 3'b000, 0, 0, 1, 1, 2, 0);
    add(3'b001, 6'h01, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2, 0);
    add(3'b001, 6'h01, 0, 0, 0, 3'b001, 0, 0, 1, 0, 2, 0);
    add(3'b001, 6'h01, 0, 0, 0, 3'b000, 1, 0, 1, 0, 2, 0);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 1, 0, 2, 0);
    add(3'b000, 6'h00, 0, 15, 0, 3'b000, 0, 0, 1, 1, 0, 1);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 1);
    // illegal code from req2
    add(3'b100, 6'h30, 0, 0, 0, 3'b100, 0, 0, 1, 0, 0, 1);
    add(3'b100, 6'h30, 0, 0, 0, 3'b000, 0, 0, 1, 1, 2, 3);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2, 3);
    // OFF while off-sequencer busy
    add(3'b010, 6'h08, 0, 0, 1, 3'b010, 0, 0, 1, 0, 2, 3);
    add(3'b010, 6'h08, 0, 0, 1, 3'b000, 0, 0, 1, 1, 1, 3);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 3);
    // ON while on-sequencer busy
    add(3'b001, 6'h01, 0, 2, 0, 3'b001, 0, 0, 1, 0, 1, 3);
    add(3'b001, 6'h01, 0, 2, 0, 3'b000, 0, 0, 1, 1, 0, 3);
    add(3'b000, 6'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 3);

    #3;
    all_out("reset", 3'b000, 0, 0, 0, 0, 2'd0, 2'd0);
    tick();
    tick();
    i_rst = 1'b1;
    tick();

    foreach (tbl[i]) begin
      set_in(tbl[i].v, tbl[i].c, tbl[i].intl,
             tbl[i].on, tbl[i].off);
      tick();
      all_out($sformatf("row%0d", i), tbl[i].rdy, tbl[i].onf,
              tbl[i].offf, tbl[i].busy, tbl[i].done,
              tbl[i].id, tbl[i].res);
    end

    // stuck off-sequencer: timeout after 100 wait cycles
    wait_tmo("tmo", 100, 2'b10);
    // completion on the last count wins over timeout
    wait_tmo("tie", 100, 2'b00);

    // reset while waiting on req1 ON (rr would be 2)
    set_in(3'b010, 6'h04, 0, 0, 0);
    tick();
    chk("pre-rst rdy", 32'(o_req_ready), 32'd2);
    tick();
    set_in(3'b000, 6'h00, 0, 0, 0);
    tick();
    chk("pre-rst busy", 32'(o_busy), 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    all_out("async rst", 3'b000, 0, 0, 0, 0, 2'd0, 2'd0);
    i_on_state = 4'd14;
    tick();
    tick();
    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-rst done%0d", k),
          32'(o_done), 32'd0);
    end
    set_in(3'b110, 6'h14, 0, 0, 0);
    tick();
    chk("post-rst rr0", 32'(o_req_ready), 32'd2);
    tick();
    chk("post-rst onf", 32'(o_op_on_flag), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mps_op_cmd_arbiter.md
MPS_OP_CMD_ARBITER -- requirements
Module: mps_op_cmd_arbiter

Interface
REQ-001 Parameter: P_TIMEOUT, default 32'd500_000_000, WAIT_DONE limit in i_clk cycles (5 s at 100 MHz).
REQ-002 i_clk  in  1  system clock; all logic on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  in  3  per-requester command valid; [0]=PS software, [1]=remote, [2]=local panel.
REQ-005 i_req_cmd  in  6  2 bits per requester, [2k+1:2k]: 01=ON, 10=OFF, 00/11=illegal.
REQ-006 o_req_ready  out  3  one-hot accept strobe to the granted requester.
REQ-007 i_intl  in  1  operation interlock, level.
REQ-008 i_on_state  in  4  on-sequencer state; 0=IDLE, 14=SYSTEM_ON, 15=FAIL.
REQ-009 i_off_state  in  4  off-sequencer state; 0=IDLE, 3=SYSTEM_OFF.
REQ-010 o_op_on_flag  out  1  one-cycle ON request pulse to the sequencer.
REQ-011 o_op_off_flag  out  1  one-cycle OFF request pulse to the sequencer.
REQ-012 o_busy  out  1  high in every state except IDLE.
REQ-013 o_done  out  1  one-cycle completion strobe.
REQ-014 o_done_id  out  2  requester index of the completed command.
REQ-015 o_result  out  2  00=OK, 01=FAIL, 10=TIMEOUT, 11=REJECT.

Function
REQ-016 FSM states SHALL be IDLE, GRANT, ISSUE, WAIT_DONE, REPORT; all outputs registered.
REQ-017 IDLE: any i_req_valid high -> GRANT next cycle; winner chosen from valid bits sampled in IDLE.
REQ-018 Priority: OFF-coded requests beat ON-coded and illegal-coded; within a class, round-robin from pointer rr_ptr (0..2).
REQ-019 rr_ptr SHALL advance to (winner+1) mod 3 on every GRANT, including rejected grants.
REQ-020 GRANT (exactly 1 cycle): o_req_ready[winner]=1, winner's cmd latched; requesters SHALL hold valid/cmd until ready.
REQ-021 Reject in GRANT -> REPORT with REJECT: illegal cmd; ON while i_intl=1 or i_on_state!=0; OFF while i_off_state!=0.
REQ-022 Accepted -> ISSUE: o_op_on_flag or o_op_off_flag high for exactly that one cycle, then WAIT_DONE.
REQ-023 WAIT_DONE ON: i_on_state==14 -> OK; i_on_state==15 -> FAIL; i_intl alone is not a completion.
REQ-024 WAIT_DONE OFF: i_off_state==3 -> OK.
REQ-025 Timeout counter, 32-bit, clears on entering WAIT_DONE, +1 per WAIT_DONE cycle; reaching P_TIMEOUT-1 with no completion -> TIMEOUT.
REQ-026 Completion and timeout in the same cycle: completion result wins.
REQ-027 REPORT (1 cycle): o_done=1, o_done_id and o_result valid; next state IDLE; o_done_id/o_result hold until next REPORT.
REQ-028 New requests arriving while busy SHALL not be acknowledged; they wait for IDLE.
REQ-029 Minimum IDLE-to-flag latency: valid in IDLE cycle N -> ready at N+1 -> flag at N+2.

Reset
REQ-030 i_rst low SHALL force state IDLE, rr_ptr=0, timeout counter=0, all outputs 0, independent of i_clk.
REQ-031 Reset mid-command SHALL abandon it with no o_done; first post-reset grant starts from rr_ptr=0.

Verification
REQ-032 Req[1] ON, states idle, i_intl=0 -> ready=3'b010, on_flag 1 cycle; i_on_state->14 -> o_done, id=1, result=00.
REQ-033 Req[0] ON + req[2] OFF same cycle -> req[2] granted first (OFF priority); req[0] served next, after REPORT.
REQ-034 Req[0..2] all ON, held, each served to OK in turn -> grant order 0,1,2, rr_ptr=0 after third.
REQ-035 ON with i_intl=1 -> REJECT (11), no flag; ON accepted then i_on_state=15 -> FAIL (01).
REQ-036 P_TIMEOUT=100, OFF accepted, i_off_state stuck at 1 -> o_done 100 cycles after entering WAIT_DONE, result=10.
REQ-037 i_rst low during WAIT_DONE -> outputs 0 immediately; no o_done; next request granted normally.
